oam_dma_ctrl: RTL and testbench

- CPU-side bus initiator for sprite DMA: detects a CPU write to the DMA trigger register, halts the CPU, and copies 256 bytes from CPU page {page,8'h00} to the OAM data port.
- It reads each byte through the memory controller's CPU port, then writes it to 0x2004; the memory controller auto-increments the SPRAM address on each write.
- Sits between the CPU core and the memory controller. bus_grant drives the top-level mux that selects DMA or CPU signals onto the controller's cpu_addr/cpu_data_in/cpu_write_en/cpu_read_en.

---
 rtl/oam_dma_ctrl.sv | 111 +++++++++++
 tb/tb_oam_dma_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_ctrl.sv
// Sprite DMA initiator: on a CPU write to the trigger register it halts the CPU and copies
// one 256-byte page to the OAM data port as alternating read/write bus cycles.
module oam_dma_ctrl #(
    parameter logic [15:0] TRIGGER_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
    parameter bit          ALIGN_ENABLE  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data_in,
    input  logic        cpu_write_en,
    input  logic [7:0]  mem_data_in,
    output logic        cpu_halt,
    output logic        bus_grant,
    output logic [15:0] dma_addr,
    output logic [7:0]  dma_data_out,
    output logic        dma_read_en,
    output logic        dma_write_en,
    output logic        dma_done
);

    typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE, DONE} state_t;

    state_t      state;
    logic [7:0]  page;
    logic [7:0]  idx;
    logic [7:0]  idx_nxt;
    logic        cyc_odd;
    logic        trigger;

    assign trigger = cpu_write_en && (cpu_addr == TRIGGER_ADDR);
    assign idx_nxt = idx + 8'd1;

    // Read data arrives registered one cycle after the READ strobe, so it is forwarded straight through.
    assign dma_data_out = dma_write_en ? mem_data_in : 8'h00;

    // Outputs are loaded together with the state they belong to, so they change only on clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            page         <= 8'h00;
            idx          <= 8'h00;
            cyc_odd      <= 1'b0;
            cpu_halt     <= 1'b0;
            bus_grant    <= 1'b0;
            dma_addr     <= 16'h0000;
            dma_read_en  <= 1'b0;
            dma_write_en <= 1'b0;
            dma_done     <= 1'b0;
        end else begin
            cyc_odd      <= ~cyc_odd;
            dma_addr     <= 16'h0000;
            dma_read_en  <= 1'b0;
            dma_write_en <= 1'b0;
            dma_done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        page      <= cpu_data_in;
                        idx       <= 8'h00;
                        state     <= HALT;
                        cpu_halt  <= 1'b1;
                        bus_grant <= 1'b1;
                    end
                end
                HALT: begin
                    if (ALIGN_ENABLE && cyc_odd) begin
                        state <= ALIGN;
                    end else begin
                        state       <= READ;
                        dma_addr    <= {page, idx};
                        dma_read_en <= 1'b1;
                    end
                end
                ALIGN: begin
                    state       <= READ;
                    dma_addr    <= {page, idx};
                    dma_read_en <= 1'b1;
                end
                READ: begin
                    state        <= WRITE;
                    dma_addr     <= OAM_DATA_ADDR;
                    dma_write_en <= 1'b1;
                end
                WRITE: begin
                    if (idx == 8'hFF) begin
                        state     <= DONE;
                        cpu_halt  <= 1'b0;
                        bus_grant <= 1'b0;
                        dma_done  <= 1'b1;
                    end else begin
                        idx         <= idx_nxt;
                        state       <= READ;
                        dma_addr    <= {page, idx_nxt};
                        dma_read_en <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    cpu_halt  <= 1'b0;
                    bus_grant <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl: a registered-read memory model feeds the DMA and a
// monitor records every bus cycle; a second instance has alignment disabled.
`timescale 1ns/1ps
module tb_oam_dma_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_data_in = 8'h00;
    logic        cpu_write_en = 1'b0;
    logic [7:0]  rd_q = 8'h00;

    logic        cpu_halt, bus_grant, dma_read_en, dma_write_en, dma_done;
    logic [15:0] dma_addr;
    logic [7:0]  dma_data_out;
    logic        cpu_halt0, bus_grant0, dma_read_en0, dma_write_en0, dma_done0;
    logic [15:0] dma_addr0;
    logic [7:0]  dma_data_out0;

    always #5 clk = ~clk;

    oam_dma_ctrl u_dut (
        .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in),
        .cpu_write_en(cpu_write_en), .mem_data_in(rd_q), .cpu_halt(cpu_halt),
        .bus_grant(bus_grant), .dma_addr(dma_addr), .dma_data_out(dma_data_out),
        .dma_read_en(dma_read_en), .dma_write_en(dma_write_en), .dma_done(dma_done)
    );

    oam_dma_ctrl #(.ALIGN_ENABLE(1'b0)) u_dut_noalign (
        .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in),
        .cpu_write_en(cpu_write_en), .mem_data_in(rd_q), .cpu_halt(cpu_halt0),
        .bus_grant(bus_grant0), .dma_addr(dma_addr0), .dma_data_out(dma_data_out0),
        .dma_read_en(dma_read_en0), .dma_write_en(dma_write_en0), .dma_done(dma_done0)
    );

    // Source bytes: page 0x02 holds i^0x5A; other pages fold the page in so a wrong page shows up.
    function automatic logic [7:0] src(input logic [15:0] a);
        return a[7:0] ^ 8'h5A ^ (a[15:8] - 8'h02);
    endfunction

    always @(posedge clk) begin
        if (dma_read_en) rd_q <= src(dma_addr);
    end

    // Reference for the DUT's free-running cycle parity.
    logic tb_odd;
    always @(posedge clk or posedge rst) begin
        if (rst) tb_odd <= 1'b0;
        else     tb_odd <= ~tb_odd;
    end

    int          halt_cnt = 0, halt0_cnt = 0, grant_cnt = 0, rd_cnt = 0, wr_cnt = 0;
    int          done_cnt = 0, addr_err = 0, inv_err = 0, hit_0800 = 0;
    logic [7:0]  rd_idx = 8'h00, wr_idx = 8'h00, exp_page = 8'h00;
    logic [15:0] last_rd = 16'h0000;
    logic        prev_halt = 1'b0, prev_rd = 1'b0;
    logic [7:0]  spram [256];

    always @(posedge clk) begin
        #1;
        if (cpu_halt)  halt_cnt++;
        if (cpu_halt0) halt0_cnt++;
        if (bus_grant) grant_cnt++;
        if (dma_done)  done_cnt++;
        if (cpu_halt && !prev_halt) begin
            rd_idx = 8'h00;
            wr_idx = 8'h00;
        end
        if (dma_read_en) begin
            rd_cnt++;
            if (dma_addr != {exp_page, rd_idx}) addr_err++;
            if (dma_addr == 16'h0800) hit_0800++;
            if (prev_rd) inv_err++;
            last_rd = dma_addr;
            rd_idx++;
        end
        if (dma_write_en) begin
            wr_cnt++;
            if (dma_addr != 16'h2004) addr_err++;
            if (!prev_rd) inv_err++;
            spram[wr_idx] = dma_data_out;
            wr_idx++;
        end else if (prev_rd && !rst) begin
            inv_err++;
        end
        if (bus_grant != cpu_halt) inv_err++;
        if ((dma_read_en || dma_write_en) && !cpu_halt) inv_err++;
        if (dma_read_en && dma_write_en) inv_err++;
        if (!dma_read_en && !dma_write_en && dma_addr != 16'h0000) inv_err++;
        if (!dma_write_en && dma_data_out != 8'h00) inv_err++;
        prev_halt = cpu_halt;
        prev_rd   = dma_read_en;
    end

    int n_cmp = 0, n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int b_halt, b_halt0, b_grant, b_rd, b_wr, b_done, b_addr, b_hit;

    task automatic snap();
        b_halt = halt_cnt; b_halt0 = halt0_cnt; b_grant = grant_cnt; b_rd = rd_cnt;
        b_wr = wr_cnt; b_done = done_cnt; b_addr = addr_err; b_hit = hit_0800;
    endtask

    // Called at a negedge; trigger is sampled on the following rising edge.
    task automatic trig(input logic [15:0] a, input logic [7:0] d);
        cpu_addr = a; cpu_data_in = d; cpu_write_en = 1'b1;
        @(negedge clk);
        cpu_addr = 16'h0000; cpu_data_in = 8'h00; cpu_write_en = 1'b0;
    endtask

    // Arrange for the HALT cycle to see the requested cycle parity.
    task automatic align_to(input logic want_odd);
        if (tb_odd == want_odd) @(negedge clk);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!dma_done && n < 1200) begin
            @(negedge clk);
            n++;
        end
        check({tag, " done_seen"}, {31'd0, dma_done}, 32'd1);
    endtask

    task automatic check_xfer(input string tag, input logic [7:0] pg, input int exp_halt);
        int bad = 0;
        check({tag, " halt_cycles"}, halt_cnt - b_halt, exp_halt);
        check({tag, " halt_cycles_noalign"}, halt0_cnt - b_halt0, 513);
        check({tag, " reads"}, rd_cnt - b_rd, 256);
        check({tag, " writes"}, wr_cnt - b_wr, 256);
        check({tag, " done_pulses"}, done_cnt - b_done, 1);
        check({tag, " addr_errors"}, addr_err - b_addr, 0);
        check({tag, " last_read"}, {16'd0, last_rd}, {16'd0, pg, 8'hFF});
        for (int i = 0; i < 256; i++) begin
            logic [15:0] a;
            a = {pg, i[7:0]};
            if (spram[i] !== src(a)) bad++;
        end
        check({tag, " spram_bad_bytes"}, bad, 0);
    endtask

    initial begin
        logic [15:0] hit;
        int          n;
        int          exp_h;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst cpu_halt", {31'd0, cpu_halt}, 0);
        check("rst bus_grant", {31'd0, bus_grant}, 0);
        check("rst dma_read_en", {31'd0, dma_read_en}, 0);
        check("rst dma_write_en", {31'd0, dma_write_en}, 0);
        check("rst dma_done", {31'd0, dma_done}, 0);
        check("rst dma_addr", {16'd0, dma_addr}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Near-miss addresses must not start a transfer
        snap();
        trig(16'h4015, 8'h02);
        trig(16'h2014, 8'h02);
        repeat (5) @(negedge clk);
        check("nontrig halt", halt_cnt - b_halt, 0);
        check("nontrig grant", grant_cnt - b_grant, 0);
        check("nontrig reads", rd_cnt - b_rd, 0);

        // Even start, page 0x02
        exp_page = 8'h02;
        align_to(1'b0);
        snap();
        trig(16'h4014, 8'h02);
        wait_done("even");
        check_xfer("even", 8'h02, 513);
        repeat (3) @(negedge clk);

        // Odd start inserts one ALIGN cycle (not in the no-align instance)
        align_to(1'b1);
        snap();
        trig(16'h4014, 8'h02);
        wait_done("odd");
        check_xfer("odd", 8'h02, 514);
        repeat (3) @(negedge clk);

        // Page 0x07 with an ignored retrigger during READ, then back-to-back trigger
        exp_page = 8'h07;
        align_to(1'b0);
        snap();
        trig(16'h4014, 8'h07);
        n = 0;
        while (!dma_read_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("retrig in_read", {31'd0, dma_read_en}, 1);
        trig(16'h4014, 8'h05);
        wait_done("wrap");
        check_xfer("wrap", 8'h07, 513);
        check("wrap no_0800", hit_0800 - b_hit, 0);
        @(negedge clk);
        exp_page = 8'h03;
        exp_h = (tb_odd == 1'b0) ? 514 : 513;
        snap();
        trig(16'h4014, 8'h03);
        wait_done("b2b");
        check_xfer("b2b", 8'h03, exp_h);
        repeat (3) @(negedge clk);

        // Reset while idx = 0x40
        exp_page = 8'h04;
        trig(16'h4014, 8'h04);
        n = 0;
        hit = 16'h0440;
        while (!(dma_read_en && dma_addr == hit) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("midrst reached_idx40", {16'd0, dma_addr}, {16'd0, hit});
        rst = 1'b1;
        #1;
        check("midrst cpu_halt", {31'd0, cpu_halt}, 0);
        check("midrst bus_grant", {31'd0, bus_grant}, 0);
        check("midrst dma_read_en", {31'd0, dma_read_en}, 0);
        check("midrst dma_write_en", {31'd0, dma_write_en}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("postrst idle_halt", {31'd0, cpu_halt}, 0);
        exp_page = 8'h01;
        align_to(1'b0);
        snap();
        trig(16'h4014, 8'h01);
        wait_done("postrst");
        check_xfer("postrst", 8'h01, 513);
        repeat (3) @(negedge clk);

        check("bus invariants", inv_err, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
